// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the 7-segment scan controller.
// Segment bit order is {a,b,c,d,e,f,g}, active-high.
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      BLANK
   } state_e;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-segment decoder; non-decimal nibbles show nothing.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display.
// Frames arrive over valid/ready and are swapped in only at frame boundaries.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    lz_blank,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [4*NUM_DIGITS-1:0] wr_data,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg
);

   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] DRV_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   state_e                       state_q,   state_d;
   logic [IW-1:0]                idx_q,     idx_d;
   logic [CW-1:0]                cnt_q,     cnt_d;
   logic                         pending_q, pending_d;
   logic [NUM_DIGITS-1:0][3:0]   shadow_q,  shadow_d;
   logic [NUM_DIGITS-1:0][3:0]   active_q,  active_d;
   logic [NUM_DIGITS-1:0]        an_q,      an_d;
   logic [6:0]                   seg_q,     seg_d;

   logic                         xfer;
   logic                         commit;
   logic [3:0]                   cur_digit;
   logic [6:0]                   dec_seg;
   logic [NUM_DIGITS:0]          upper_zero;
   logic                         lz_dark;

   assign cur_digit = active_q[idx_q];

   seg7_decode u_decode (
      .digit (cur_digit),
      .seg   (dec_seg)
   );

   // upper_zero[i]: digit i and every digit above it are zero
   always_comb begin
      upper_zero             = '0;
      upper_zero[NUM_DIGITS] = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         upper_zero[i] = upper_zero[i+1] && (active_q[i] == 4'd0);
      end
   end

   assign lz_dark = lz_blank && (idx_q != '0) && upper_zero[idx_q];

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      commit    = 1'b0;
      xfer      = wr_valid && !pending_q;

      if (!enable) begin
         state_d = IDLE;
         idx_d   = '0;
         cnt_d   = '0;
         commit  = pending_q;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = DRIVE;
               idx_d   = '0;
               cnt_d   = '0;
               commit  = pending_q;
            end
            DRIVE: begin
               if (cnt_q == DRV_LAST) begin
                  state_d = BLANK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            BLANK: begin
               if (cnt_q == BLK_LAST) begin
                  state_d = DRIVE;
                  cnt_d   = '0;
                  if (idx_q == IDX_LAST) begin
                     idx_d  = '0;
                     commit = pending_q;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // commit reads the old shadow before any same-cycle write lands
      if (commit) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (xfer) begin
         shadow_d  = wr_data;
         pending_d = 1'b1;
      end
   end

   // outputs follow the current state one register later
   always_comb begin
      an_d  = '1;
      seg_d = SEG_BLANK;
      if (state_q == DRIVE) begin
         an_d[idx_q] = 1'b0;
         seg_d       = lz_dark ? SEG_BLANK : dec_seg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         shadow_q  <= '0;
         active_q  <= '0;
         an_q      <= '1;
         seg_q     <= SEG_BLANK;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign wr_ready = !pending_q;
   assign an       = an_q;
   assign seg      = seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-time reference model predicts
// every output cycle; a separate monitor pops and compares.
module tb_seg7_scan_ctrl;

   localparam int N     = 4;
   localparam int DIV   = 4;
   localparam int BLK   = 2;
   localparam int SLOT  = DIV + BLK;
   localparam int FRAME = N * SLOT;

   localparam logic [6:0] PAT [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
   };

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b1;
   logic        enable   = 1'b1;
   logic        lz_blank = 1'b0;
   logic        wr_valid = 1'b0;
   logic [15:0] wr_data  = 16'h0;
   logic        wr_ready;
   logic [3:0]  an;
   logic [6:0]  seg;

   seg7_scan_ctrl #(
      .NUM_DIGITS   (N),
      .REFRESH_DIV  (DIV),
      .BLANK_CYCLES (BLK)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .lz_blank (lz_blank),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_data  (wr_data),
      .an       (an),
      .seg      (seg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       rdy;
   } obs_t;

   obs_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // reference model: scan position is plain elapsed time within the frame
   bit          m_on;
   int          m_t;
   logic [15:0] m_act;
   logic [15:0] m_sh;
   bit          m_pend;

   task automatic model_reset();
      m_on   = 1'b0;
      m_t    = 0;
      m_act  = 16'h0;
      m_sh   = 16'h0;
      m_pend = 1'b0;
   endtask

   function automatic obs_t model_out(input bit lz);
      obs_t       o;
      int         pos;
      int         ph;
      logic [3:0] d;
      o = {4'hF, 7'h00, 1'b1};
      if (m_on) begin
         pos = m_t / SLOT;
         ph  = m_t % SLOT;
         if (ph < DIV) begin
            o.an[pos] = 1'b0;
            d         = m_act[4*pos +: 4];
            if (lz && pos > 0 && (m_act >> (4*pos)) == 16'h0) o.seg = 7'h00;
            else                                               o.seg = PAT[d];
         end
      end
      return o;
   endfunction

   task automatic model_edge(input bit en, input bit wv, input logic [15:0] wd);
      bit xfer;
      bit commit;
      xfer   = wv && !m_pend;
      commit = 1'b0;
      if (!en) begin
         commit = m_pend;
         m_on   = 1'b0;
         m_t    = 0;
      end else if (!m_on) begin
         commit = m_pend;
         m_on   = 1'b1;
         m_t    = 0;
      end else begin
         m_t++;
         if (m_t == FRAME) begin
            m_t    = 0;
            commit = m_pend;
         end
      end
      if (commit) begin
         m_act  = m_sh;
         m_pend = 1'b0;
      end
      if (xfer) begin
         m_sh   = wd;
         m_pend = 1'b1;
      end
   endtask

   // one clock of stimulus; pushes what the DUT must show after the next edge
   task automatic step(input bit r, input bit en, input bit lz, input bit wv,
                       input logic [15:0] wd);
      obs_t e;
      @(negedge clk);
      rst_n    = r;
      enable   = en;
      lz_blank = lz;
      wr_valid = wv;
      wr_data  = wd;
      if (!r) begin
         model_reset();
         e = {4'hF, 7'h00, 1'b1};
         #1;
         checks++;
         if ({an, seg, wr_ready} !== e)
            $display("FAIL reset_async: got an=%b seg=%b rdy=%b, want an=%b seg=%b rdy=%b",
                     an, seg, wr_ready, e.an, e.seg, e.rdy);
         if ({an, seg, wr_ready} !== e) errors++;
      end else begin
         e = model_out(lz);
         model_edge(en, wv, wd);
         e.rdy = !m_pend;
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n, input bit en, input bit lz);
      repeat (n) step(1'b1, en, lz, 1'b0, 16'($urandom));
   endtask

   task automatic aim(input int t);
      for (int k = 0; k < 100 && m_t != t; k++) idle(1, 1'b1, 1'b0);
   endtask

   initial begin : monitor
      obs_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, wr_ready} !== e) begin
               errors++;
               $display("FAIL scan @%0t: got an=%b seg=%b rdy=%b, want an=%b seg=%b rdy=%b",
                        $time, an, seg, wr_ready, e.an, e.seg, e.rdy);
            end
         end
      end
   end

   initial begin : stim
      bit r;
      bit en;
      bit lz;
      bit wv;
      model_reset();

      // reset held with enable high, then free scan of an all-zero frame
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      idle(30, 1'b1, 1'b0);

      // single frame write, committed at the next frame end
      step(1'b1, 1'b1, 1'b0, 1'b1, 16'h1278);
      idle(60, 1'b1, 1'b0);

      // write while pending is stalled; write on the frame-end edge waits a frame
      step(1'b1, 1'b1, 1'b0, 1'b1, 16'h4321);
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 16'h9999);
      for (int k = 0; k < 100 && (m_pend || m_t != FRAME - 1); k++) idle(1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 16'h5555);
      idle(50, 1'b1, 1'b0);

      // leading-zero blanking
      step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0070);
      idle(50, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 16'h000A);
      idle(50, 1'b1, 1'b1);

      // enable dropped mid-DRIVE of digit 2 with a frame pending
      aim(8);
      step(1'b1, 1'b1, 1'b0, 1'b1, 16'h3456);
      aim(13);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      idle(3, 1'b0, 1'b0);
      idle(30, 1'b1, 1'b0);

      // reset mid-BLANK discards the pending frame
      aim(7);
      step(1'b1, 1'b1, 1'b0, 1'b1, 16'h9876);
      aim(10);
      repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      idle(30, 1'b1, 1'b0);

      // randomized traffic
      lz = 1'b0;
      repeat (2000) begin
         r  = ($urandom % 400) != 0;
         en = ($urandom % 40) != 0;
         if ($urandom % 100 == 0) lz = !lz;
         wv = ($urandom % 6) == 0;
         step(r, en, lz, wv, 16'($urandom));
      end
      idle(3, 1'b1, 1'b0);

      @(posedge clk);
      #4;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
